// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller
//   Central stall/flush/nop sequencer for the 5-stage pipeline (PC, IF/ID,
//   ID/EX, EX/MEM, MEM/WB). Resolves load-use hazards, branch mispredicts,
//   instruction-fetch misses and multi-cycle data-memory waits, and runs a
//   debug halt -> drain -> halted -> resume sequence.
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   id_rs_i, id_rt_i        source registers of the instruction in ID
//   id_uses_rt_i            ID instruction reads rt
//   ex_dst_i                destination register of the instruction in EX
//   ex_mem_to_reg_i         EX instruction is a load
//   ex_reg_write_i          EX instruction writes a register
//   mispredict_i            branch resolved in EX disagrees with prediction
//   imem_ready_i            instruction memory returned a word this cycle
//   mem_access_i            MEM-stage instruction performs a memory op
//   dmem_ready_i            data memory completes its access this cycle
//   halt_req_i              level debug halt request
//   pc_stall_o/pc_redirect_o           hold PC / load corrected target
//   <reg>_stall_o/_flush_o/_nop_o      per pipeline register controls
//   halted_o                pipeline drained and frozen
//   mem_timeout_o           sticky data-memory wait timeout error
//
// All outputs are combinational from registered state and current inputs.
module pipeline_hazard_controller #(
    parameter int REG_BITS     = 5,
    parameter int DRAIN_CYCLES = 4,
    parameter int MEM_TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [REG_BITS-1:0] id_rs_i,
    input  logic [REG_BITS-1:0] id_rt_i,
    input  logic                id_uses_rt_i,
    input  logic [REG_BITS-1:0] ex_dst_i,
    input  logic                ex_mem_to_reg_i,
    input  logic                ex_reg_write_i,
    input  logic                mispredict_i,
    input  logic                imem_ready_i,
    input  logic                mem_access_i,
    input  logic                dmem_ready_i,
    input  logic                halt_req_i,
    output logic                pc_stall_o,
    output logic                pc_redirect_o,
    output logic                if_id_stall_o,
    output logic                if_id_flush_o,
    output logic                if_id_nop_o,
    output logic                id_ex_stall_o,
    output logic                id_ex_flush_o,
    output logic                id_ex_nop_o,
    output logic                ex_mem_stall_o,
    output logic                ex_mem_flush_o,
    output logic                ex_mem_nop_o,
    output logic                mem_wb_stall_o,
    output logic                mem_wb_flush_o,
    output logic                mem_wb_nop_o,
    output logic                halted_o,
    output logic                mem_timeout_o
);

    localparam int WAIT_W  = 8;
    localparam int DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES);

    localparam logic [WAIT_W-1:0]  WAIT_MAX   = WAIT_W'(MEM_TIMEOUT);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_e;

    state_e              state_q, state_d;
    logic [DRAIN_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                mem_timeout_q, mem_timeout_d;

    logic memwait;
    logic load_use;
    logic frozen;

    assign memwait  = mem_access_i & ~dmem_ready_i;
    assign load_use = ex_mem_to_reg_i & ex_reg_write_i & (ex_dst_i != '0) &
                      ((ex_dst_i == id_rs_i) | (id_uses_rt_i & (ex_dst_i == id_rt_i)));
    // HALTED with the request still up is the only fully frozen cycle; once
    // halt_req drops the RUN rules take over in that same cycle.
    assign frozen   = (state_q == HALTED) & halt_req_i;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            drain_cnt_q   <= '0;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            drain_cnt_q   <= drain_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            RUN, MEM_WAIT: begin
                if (memwait) begin
                    state_d = MEM_WAIT;
                end else if (halt_req_i) begin
                    state_d     = DRAIN;
                    drain_cnt_d = '0;
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                // A data-memory wait freezes the drain without counting.
                if (!memwait) begin
                    if (drain_cnt_q == DRAIN_LAST) state_d = HALTED;
                    else                           drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            HALTED: begin
                if (!halt_req_i) state_d = memwait ? MEM_WAIT : RUN;
            end
            default: state_d = RUN;
        endcase

        // Consecutive wait cycles, saturating; any non-wait cycle clears it.
        wait_cnt_d = '0;
        if (memwait && !frozen)
            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
        mem_timeout_d = mem_timeout_q | (wait_cnt_d == WAIT_MAX);
    end

    // --------------------------------------------------------------- outputs
    always_comb begin
        pc_stall_o     = 1'b0;
        pc_redirect_o  = 1'b0;
        if_id_stall_o  = 1'b0;
        if_id_flush_o  = 1'b0;
        if_id_nop_o    = 1'b0;
        id_ex_stall_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        id_ex_nop_o    = 1'b0;
        ex_mem_stall_o = 1'b0;
        ex_mem_flush_o = 1'b0;
        ex_mem_nop_o   = 1'b0;
        mem_wb_stall_o = 1'b0;
        mem_wb_flush_o = 1'b0;
        mem_wb_nop_o   = 1'b0;
        halted_o       = 1'b0;
        mem_timeout_o  = mem_timeout_q;

        if (!rst_n) begin
            pc_stall_o     = 1'b1;
            if_id_flush_o  = 1'b1;
            id_ex_flush_o  = 1'b1;
            ex_mem_flush_o = 1'b1;
            mem_wb_flush_o = 1'b1;
        end else if (frozen) begin
            pc_stall_o     = 1'b1;
            if_id_stall_o  = 1'b1;
            if_id_nop_o    = 1'b1;
            id_ex_stall_o  = 1'b1;
            id_ex_nop_o    = 1'b1;
            ex_mem_stall_o = 1'b1;
            ex_mem_nop_o   = 1'b1;
            mem_wb_stall_o = 1'b1;
            mem_wb_nop_o   = 1'b1;
            halted_o       = 1'b1;
        end else if (memwait) begin
            // Hold everything upstream of MEM; bubble into WB. A mispredict
            // sitting in EX is simply held and re-evaluated on release.
            pc_stall_o     = 1'b1;
            if_id_stall_o  = 1'b1;
            id_ex_stall_o  = 1'b1;
            ex_mem_stall_o = 1'b1;
            mem_wb_flush_o = 1'b1;
        end else if (state_q == DRAIN) begin
            // Stop fetching and let older instructions retire.
            pc_stall_o    = ~mispredict_i;
            pc_redirect_o = mispredict_i;
            if_id_flush_o = 1'b1;
            id_ex_flush_o = mispredict_i;
        end else if (mispredict_i) begin
            // Wins over load-use: the dependent ID instruction is squashed.
            pc_redirect_o = 1'b1;
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
        end else if (load_use) begin
            pc_stall_o    = 1'b1;
            if_id_stall_o = 1'b1;
            id_ex_flush_o = 1'b1;
        end else if (!imem_ready_i) begin
            pc_stall_o    = 1'b1;
            if_id_flush_o = 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
module tb_pipeline_hazard_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, ex_dst;
    logic       id_uses_rt, ex_mem_to_reg, ex_reg_write, mispredict;
    logic       imem_ready, mem_access, dmem_ready, halt_req;
    logic       pc_stall, pc_redirect;
    logic       if_id_stall, if_id_flush, if_id_nop;
    logic       id_ex_stall, id_ex_flush, id_ex_nop;
    logic       ex_mem_stall, ex_mem_flush, ex_mem_nop;
    logic       mem_wb_stall, mem_wb_flush, mem_wb_nop;
    logic       halted, mem_timeout;
    logic [15:0] dut_out;

    always #5 clk = ~clk;

    pipeline_hazard_controller #(
        .REG_BITS(5), .DRAIN_CYCLES(4), .MEM_TIMEOUT(255)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(id_uses_rt),
        .ex_dst_i(ex_dst), .ex_mem_to_reg_i(ex_mem_to_reg), .ex_reg_write_i(ex_reg_write),
        .mispredict_i(mispredict), .imem_ready_i(imem_ready),
        .mem_access_i(mem_access), .dmem_ready_i(dmem_ready), .halt_req_i(halt_req),
        .pc_stall_o(pc_stall), .pc_redirect_o(pc_redirect),
        .if_id_stall_o(if_id_stall), .if_id_flush_o(if_id_flush), .if_id_nop_o(if_id_nop),
        .id_ex_stall_o(id_ex_stall), .id_ex_flush_o(id_ex_flush), .id_ex_nop_o(id_ex_nop),
        .ex_mem_stall_o(ex_mem_stall), .ex_mem_flush_o(ex_mem_flush), .ex_mem_nop_o(ex_mem_nop),
        .mem_wb_stall_o(mem_wb_stall), .mem_wb_flush_o(mem_wb_flush), .mem_wb_nop_o(mem_wb_nop),
        .halted_o(halted), .mem_timeout_o(mem_timeout)
    );

    assign dut_out = {pc_stall, pc_redirect, if_id_stall, if_id_flush, if_id_nop,
                      id_ex_stall, id_ex_flush, id_ex_nop, ex_mem_stall, ex_mem_flush,
                      ex_mem_nop, mem_wb_stall, mem_wb_flush, mem_wb_nop, halted, mem_timeout};

    localparam logic [15:0] B_PCS = 16'h8000, B_PCR = 16'h4000;
    localparam logic [15:0] B_IFS = 16'h2000, B_IFF = 16'h1000, B_IFN = 16'h0800;
    localparam logic [15:0] B_IXS = 16'h0400, B_IXF = 16'h0200, B_IXN = 16'h0100;
    localparam logic [15:0] B_XMS = 16'h0080, B_XMF = 16'h0040, B_XMN = 16'h0020;
    localparam logic [15:0] B_MWS = 16'h0010, B_MWF = 16'h0008, B_MWN = 16'h0004;
    localparam logic [15:0] B_HLT = 16'h0002, B_TMO = 16'h0001;

    localparam logic [15:0] E_ZERO  = 16'h0000;
    localparam logic [15:0] E_RST   = B_PCS | B_IFF | B_IXF | B_XMF | B_MWF;
    localparam logic [15:0] E_LU    = B_PCS | B_IFS | B_IXF;
    localparam logic [15:0] E_WAIT  = B_PCS | B_IFS | B_IXS | B_XMS | B_MWF;
    localparam logic [15:0] E_MISP  = B_PCR | B_IFF | B_IXF;
    localparam logic [15:0] E_IMISS = B_PCS | B_IFF;
    localparam logic [15:0] E_DRAIN = B_PCS | B_IFF;
    localparam logic [15:0] E_HALT  = B_PCS | B_IFS | B_IFN | B_IXS | B_IXN | B_XMS |
                                      B_XMN | B_MWS | B_MWN | B_HLT;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic [4:0] dst;
        logic       m2r;
        logic       rw;
        logic       misp;
        logic       imem;
        logic       macc;
        logic       dmem;
        logic       halt;
    } in_t;

    typedef struct {
        in_t         in;
        logic [15:0] exp;
        string       name;
    } vec_t;

    typedef struct {
        logic [15:0] exp;
        string       name;
    } sb_t;

    sb_t sb[$];
    int  checks = 0;
    int  errors = 0;

    function automatic in_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                               input logic [4:0] dst, input logic m2r, input logic rw,
                               input logic misp, input logic imem, input logic macc,
                               input logic dmem, input logic halt);
        in_t r;
        r.rs = rs; r.rt = rt; r.uses_rt = uses_rt; r.dst = dst; r.m2r = m2r; r.rw = rw;
        r.misp = misp; r.imem = imem; r.macc = macc; r.dmem = dmem; r.halt = halt;
        return r;
    endfunction

    task automatic apply(input in_t in);
        id_rs = in.rs; id_rt = in.rt; id_uses_rt = in.uses_rt; ex_dst = in.dst;
        ex_mem_to_reg = in.m2r; ex_reg_write = in.rw; mispredict = in.misp;
        imem_ready = in.imem; mem_access = in.macc; dmem_ready = in.dmem; halt_req = in.halt;
    endtask

    task automatic check_one();
        sb_t e;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty");
            return;
        end
        e = sb.pop_front();
        checks++;
        if (dut_out !== e.exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", e.name, dut_out, e.exp);
        end
    endtask

    // One cycle: drive just after the edge, sample at the falling edge.
    task automatic cyc(input in_t in, input logic [15:0] exp, input string name);
        apply(in);
        sb.push_back('{exp, name});
        @(negedge clk);
        check_one();
        @(posedge clk);
        #1;
    endtask

    in_t  idle, wait_in, halt_in;
    vec_t tbl[13];

    initial begin
        idle    = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        wait_in = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        halt_in = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1);

        tbl[0]  = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0), E_ZERO,  "idle"};
        tbl[1]  = '{mk(8, 0, 0, 8, 1, 1, 0, 1, 0, 1, 0), E_LU,    "lu_rs"};
        tbl[2]  = '{mk(3, 8, 1, 8, 1, 1, 0, 1, 0, 1, 0), E_LU,    "lu_rt"};
        tbl[3]  = '{mk(3, 8, 0, 8, 1, 1, 0, 1, 0, 1, 0), E_ZERO,  "lu_rt_unused"};
        tbl[4]  = '{mk(0, 0, 1, 0, 1, 1, 0, 1, 0, 1, 0), E_ZERO,  "lu_dst0"};
        tbl[5]  = '{mk(8, 0, 0, 8, 1, 0, 0, 1, 0, 1, 0), E_ZERO,  "lu_no_regwrite"};
        tbl[6]  = '{mk(8, 0, 0, 8, 0, 1, 0, 1, 0, 1, 0), E_ZERO,  "lu_not_load"};
        tbl[7]  = '{mk(8, 0, 0, 8, 1, 1, 1, 1, 0, 1, 0), E_MISP,  "misp_and_lu"};
        tbl[8]  = '{mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0), E_MISP,  "misp"};
        tbl[9]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), E_IMISS, "imiss"};
        tbl[10] = '{mk(8, 0, 0, 8, 1, 1, 0, 0, 0, 1, 0), E_LU,    "lu_over_imiss"};
        tbl[11] = '{mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0), E_MISP,  "misp_over_imiss"};
        tbl[12] = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0), E_ZERO,  "mem_ready_now"};

        // Reset held for three cycles.
        rst_n = 1'b0;
        apply(idle);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{E_RST, "in_reset"});
            @(negedge clk);
            check_one();
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        cyc(idle, E_ZERO, "post_reset");

        // Single-cycle RUN vectors.
        for (int i = 0; i < 13; i++) cyc(tbl[i].in, tbl[i].exp, tbl[i].name);
        cyc(idle, E_ZERO, "lu_one_cycle_only");

        // Data-memory wait of 5 cycles; a mispredict is held until release.
        for (int i = 0; i < 5; i++) begin
            in_t w;
            w = wait_in;
            w.misp = (i >= 3);
            cyc(w, E_WAIT, "dmem_wait");
        end
        cyc(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0), E_MISP, "wait_release_misp");
        cyc(idle, E_ZERO, "after_wait_no_timeout");

        // Timeout: mem_timeout visible from the 256th consecutive wait cycle.
        for (int i = 1; i <= 260; i++)
            cyc(wait_in, E_WAIT | ((i > 255) ? B_TMO : 16'h0), "timeout_wait");
        cyc(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0), B_TMO, "timeout_sticky_release");
        cyc(idle, B_TMO, "timeout_sticky_idle");
        rst_n = 1'b0;
        cyc(idle, E_RST, "timeout_reset");
        rst_n = 1'b1;
        cyc(idle, E_ZERO, "timeout_cleared");

        // Halt request held 10 cycles: 1 RUN, 4 DRAIN, 5 HALTED, then resume.
        cyc(halt_in, E_ZERO, "halt_enter");
        for (int i = 0; i < 4; i++) cyc(halt_in, E_DRAIN, "drain");
        for (int i = 0; i < 5; i++) cyc(halt_in, E_HALT, "halted");
        cyc(idle, E_ZERO, "resume_same_cycle");
        cyc(idle, E_ZERO, "resumed");

        // Drain with mispredict, a frozen wait cycle, and halt_req dropped.
        cyc(halt_in, E_ZERO, "halt2_enter");
        cyc(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1), E_MISP, "drain_misp");
        cyc(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1), E_WAIT, "drain_memwait");
        cyc(halt_in, E_DRAIN, "drain_3");
        cyc(idle, E_DRAIN, "drain_halt_dropped");
        cyc(idle, E_DRAIN, "drain_last");
        cyc(idle, E_ZERO, "halted_exit");
        cyc(idle, E_ZERO, "run_after_exit");

        // Reset mid-drain abandons the drain.
        cyc(halt_in, E_ZERO, "halt3_enter");
        cyc(halt_in, E_DRAIN, "halt3_drain");
        rst_n = 1'b0;
        cyc(halt_in, E_RST, "reset_mid_drain");
        rst_n = 1'b1;
        cyc(idle, E_ZERO, "drain_abandoned");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central stall/flush/nop sequencer for the 5-stage pipeline: PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves load-use hazards, branch mispredicts, instruction-fetch misses and multi-cycle data-memory waits.
- Also implements a halt/drain/resume sequence for debug.
- All outputs feed the stall/flush/nop inputs of the four pipeline registers plus the PC update logic.

Parameters:
REG_BITS, 5, width of register specifiers (matches `NUM_REGISTERS_LOG2)
DRAIN_CYCLES, 4, bubble cycles injected before HALTED
MEM_TIMEOUT, 255, max consecutive dmem wait cycles before error; counter width 8

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_rs, id_rt  in  REG_BITS  source registers of instruction in ID
id_uses_rt  in  1  ID instruction reads rt
ex_dst  in  REG_BITS  destination register of instruction in EX
ex_mem_to_reg, ex_reg_write  in  1  EX instruction is a load / writes a register
mispredict  in  1  branch resolved in EX disagrees with prediction
imem_ready  in  1  instruction memory returned a valid word this cycle
mem_access  in  1  MEM-stage instruction has mem_op != 0
dmem_ready  in  1  data memory completes access this cycle
halt_req  in  1  level request to halt (debug)
pc_stall, pc_redirect  out  1  hold PC / load corrected branch target
if_id_stall, if_id_flush, if_id_nop  out  1  IF/ID control
id_ex_stall, id_ex_flush, id_ex_nop  out  1  ID/EX control
ex_mem_stall, ex_mem_flush, ex_mem_nop  out  1  EX/MEM control
mem_wb_stall, mem_wb_flush, mem_wb_nop  out  1  MEM/WB control
halted  out  1  pipeline drained and frozen
mem_timeout  out  1  sticky error; set when wait counter hits MEM_TIMEOUT

Behaviour:
- Register semantics: flush zeroes at the next edge and beats stall; stall holds; nop is latched and masks outputs to zero the following cycle without altering contents.
- Outputs are combinational from state and inputs; state and counters are registered.
- While rst_n=0: state=RUN, counters=0, mem_timeout=0, every *_flush=1, every stall/nop=0, pc_stall=1, pc_redirect=0, halted=0.
- A mid-operation reset abandons any wait or drain immediately.
- FSM states: RUN, MEM_WAIT, DRAIN, HALTED.
- memwait = mem_access & !dmem_ready.
- RUN, priority highest first:
  1. memwait: pc, if_id, id_ex, ex_mem stall; mem_wb_flush=1. Next state MEM_WAIT. Any mispredict is held in EX and re-evaluated later.
  2. mispredict: pc_redirect=1; if_id_flush=1; id_ex_flush=1.
  3. Load-use (ex_mem_to_reg & ex_reg_write & ex_dst!=0 & (ex_dst==id_rs | (id_uses_rt & ex_dst==id_rt))): pc_stall=1; if_id_stall=1; id_ex_flush=1. Exactly 1 cycle.
  4. !imem_ready: pc_stall=1; if_id_flush=1.
  5. halt_req (with no memwait): go to DRAIN, drain_cnt=0. Rules 2-4 still apply that cycle.
- MEM_WAIT: same outputs as RUN rule 1; wait_cnt increments, saturating at MEM_TIMEOUT.
  - When wait_cnt reaches MEM_TIMEOUT, mem_timeout is set and stays set until reset. The stall continues.
  - On dmem_ready=1: that cycle has no stall and normal RUN rules 2-4 apply. wait_cnt clears; next state RUN, or DRAIN if halt_req.
- DRAIN: pc_stall=1; if_id_flush=1; the other registers advance.
  - mispredict still asserts pc_redirect (overrides pc_stall) and id_ex_flush.
  - memwait freezes as in MEM_WAIT and drain_cnt does not advance.
  - After DRAIN_CYCLES counted cycles, go to HALTED.
  - halt_req dropping during DRAIN still completes the drain, then HALTED exits the following cycle.
- HALTED: every stall=1, every nop=1, pc_stall=1, halted=1. When halt_req=0, go to RUN; outputs revert the same cycle, so nop deasserts at the next edge.
- Load-use with ex_dst=0 never stalls.
- Simultaneous mispredict and load-use: mispredict only, since the ID instruction is squashed anyway.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release -> during reset all *_flush=1 and pc_stall=1; first cycle after release all outputs 0.
- Load-use: ex_dst=8, ex_mem_to_reg=1, ex_reg_write=1, id_rs=8 -> pc_stall, if_id_stall, id_ex_flush high for 1 cycle. With ex_dst=0 -> no stall.
- dmem wait: mem_access=1, dmem_ready=0 for 5 cycles, then 1 -> 5 cycles of pc/if_id/id_ex/ex_mem stall with mem_wb_flush; released on cycle 6; mem_timeout=0.
- Timeout: dmem_ready=0 for 260 cycles -> mem_timeout rises at wait_cnt=255, stays 1 after dmem_ready=1, clears only on rst_n=0.
- Mispredict with simultaneous load-use -> pc_redirect=1, if_id_flush=1, id_ex_flush=1, pc_stall=0.
- Halt: pulse halt_req high for 10 cycles -> 4 DRAIN cycles with if_id_flush, then halted=1 with all stall/nop high; halt_req=0 -> RUN the same cycle, halted=0.
